ssd_scan_decoder: RTL and testbench

Receive-side monitor for the multiplexed seven-segment display bus. It samples the active-low anode, cathode and decimal-point lines produced by the display driver path and recovers per-digit hex values, decimal points and validity for up to 8 digits. It sits beside the display driver for in-system self-check, and serves as the checker in display-path benches. It is the decoder counterpart of the nibble-to-segment driver.

---
 rtl/ssd_pkg.sv | 79 +++++++
 rtl/ssd_seg_decode.sv | 24 ++
 rtl/ssd_scan_decoder.sv | 179 +++++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: segment encoding shared by the seven-segment driver and scan decoder.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package ssd_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef logic [IDX_W-1:0] idx_t;

    // Segment bit order: a is the MSB (bit 6), g is the LSB (bit 0).
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_t;

    // Active-low cathode patterns for hex values 0..F.
    localparam seg_t SEG_0 = 7'h01;
    localparam seg_t SEG_1 = 7'h4F;
    localparam seg_t SEG_2 = 7'h12;
    localparam seg_t SEG_3 = 7'h06;
    localparam seg_t SEG_4 = 7'h4C;
    localparam seg_t SEG_5 = 7'h24;
    localparam seg_t SEG_6 = 7'h20;
    localparam seg_t SEG_7 = 7'h0F;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h04;
    localparam seg_t SEG_A = 7'h08;
    localparam seg_t SEG_B = 7'h60;
    localparam seg_t SEG_C = 7'h31;
    localparam seg_t SEG_D = 7'h42;
    localparam seg_t SEG_E = 7'h30;
    localparam seg_t SEG_F = 7'h38;

    function automatic seg_t seg_encode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_encode = SEG_0;
            4'h1:    seg_encode = SEG_1;
            4'h2:    seg_encode = SEG_2;
            4'h3:    seg_encode = SEG_3;
            4'h4:    seg_encode = SEG_4;
            4'h5:    seg_encode = SEG_5;
            4'h6:    seg_encode = SEG_6;
            4'h7:    seg_encode = SEG_7;
            4'h8:    seg_encode = SEG_8;
            4'h9:    seg_encode = SEG_9;
            4'hA:    seg_encode = SEG_A;
            4'hB:    seg_encode = SEG_B;
            4'hC:    seg_encode = SEG_C;
            4'hD:    seg_encode = SEG_D;
            4'hE:    seg_encode = SEG_E;
            default: seg_encode = SEG_F;
        endcase
    endfunction

    // True when exactly one active-low anode is driven.
    function automatic logic single_low(input logic [NUM_DIGITS-1:0] an);
        int zeros;
        zeros = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) zeros = zeros + 1;
        end
        single_low = (zeros == 1);
    endfunction

    // Index of the low anode; only meaningful when single_low() holds.
    function automatic idx_t low_index(input logic [NUM_DIGITS-1:0] an);
        low_index = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) low_index = idx_t'(i);
        end
    endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// ssd_seg_decode: active-low cathode pattern -> hex nibble, inverse of seg_encode.
// Latency: combinational.
// Backpressure: none.
// Ports: cc (active-low {a..g}), err (pattern is not a hex glyph), nibble (0 when err).
module ssd_seg_decode
    import ssd_pkg::*;
(
    input  logic [6:0] cc,
    output logic       err,
    output logic [3:0] nibble
);

    always_comb begin
        err    = 1'b1;
        nibble = 4'h0;
        for (int n = 0; n < 16; n++) begin
            if (cc == seg_encode(4'(n))) begin
                err    = 1'b0;
                nibble = 4'(n);
            end
        end
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: recovers per-digit hex values, decimal points and validity from a scanned display bus.
// Latency: capture registered STABLE_CYCLES+1 edges after the bus input settles; all outputs registered.
// Backpressure: none; passive monitor, each settled digit is captured exactly once.
// Ports: clk/rst; an/cc/dp active-low bus inputs; digits/dp_out/valid/err per digit;
//        update strobes per capture; frame_done strobes when every digit has been captured.
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    ssd_scan_decoder_port_clk,
    input  logic                    ssd_scan_decoder_port_rst,
    input  logic [NUM_DIGITS-1:0]   ssd_scan_decoder_port_an,
    input  logic [6:0]              ssd_scan_decoder_port_cc,
    input  logic                    ssd_scan_decoder_port_dp,
    output logic [4*NUM_DIGITS-1:0] ssd_scan_decoder_port_digits,
    output logic [NUM_DIGITS-1:0]   ssd_scan_decoder_port_dp_out,
    output logic [NUM_DIGITS-1:0]   ssd_scan_decoder_port_valid,
    output logic [NUM_DIGITS-1:0]   ssd_scan_decoder_port_err,
    output logic                    ssd_scan_decoder_port_update,
    output logic                    ssd_scan_decoder_port_frame_done
);

    localparam int SAMPLE_W = NUM_DIGITS + 8;
    localparam int CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam int AGE_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SAMPLE_W-1:0] SAMPLE_IDLE = {{NUM_DIGITS{1'b1}}, 7'h7F, 1'b1};
    localparam logic [AGE_W-1:0]    AGE_MAX     = AGE_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_t;

    logic clk;
    logic rst;
    assign clk = ssd_scan_decoder_port_clk;
    assign rst = ssd_scan_decoder_port_rst;

    // Two-flop synchronizer plus the previous synchronized sample. The *_ok
    // flags track when each stage holds a real bus sample rather than the reset
    // value: the first real sample after reset is adopted as the reference
    // instead of being treated as a change, so a digit that was already lit
    // across reset is not captured until the bus actually moves.
    logic [SAMPLE_W-1:0] sync1, sync2, prev;
    logic                sync1_ok, sync2_ok, prev_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= SAMPLE_IDLE;
            sync2    <= SAMPLE_IDLE;
            prev     <= SAMPLE_IDLE;
            sync1_ok <= 1'b0;
            sync2_ok <= 1'b0;
            prev_ok  <= 1'b0;
        end else begin
            sync1    <= {ssd_scan_decoder_port_an, ssd_scan_decoder_port_cc, ssd_scan_decoder_port_dp};
            sync2    <= sync1;
            prev     <= sync2;
            sync1_ok <= 1'b1;
            sync2_ok <= sync1_ok;
            prev_ok  <= sync2_ok;
        end
    end

    logic [NUM_DIGITS-1:0] s_an;
    logic [6:0]            s_cc;
    logic                  s_dp;
    logic                  changed;
    idx_t                  cap_idx;
    logic                  dec_err;
    logic [3:0]            dec_nib;

    assign s_an    = sync2[SAMPLE_W-1:8];
    assign s_cc    = sync2[7:1];
    assign s_dp    = sync2[0];
    assign changed = prev_ok && (sync2 != prev);
    assign cap_idx = low_index(s_an);

    ssd_seg_decode u_seg_decode (
        .cc     (s_cc),
        .err    (dec_err),
        .nibble (dec_nib)
    );

    // Stability FSM
    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        capture  = 1'b0;
        if (changed) begin
            // The changed sample itself is the first stable sample of the new run.
            if (single_low(s_an)) begin
                state_nx = SETTLE;
                count_nx = CNT_W'(1);
            end else begin
                state_nx = IDLE;
                count_nx = '0;
            end
        end else begin
            case (state)
                SETTLE: begin
                    if (count == CNT_LAST) begin
                        capture  = 1'b1;
                        state_nx = HELD;
                        count_nx = '0;
                    end else begin
                        count_nx = count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-digit capture registers, age counters and frame tracking
    logic [4*NUM_DIGITS-1:0] digits_r;
    logic [NUM_DIGITS-1:0]   dp_r, valid_r, err_r, seen, seen_nx;
    logic                    update_r, frame_r;
    logic [AGE_W-1:0]        age [NUM_DIGITS];

    assign seen_nx = seen | (NUM_DIGITS'(1) << cap_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_r <= '0;
            dp_r     <= '0;
            valid_r  <= '0;
            err_r    <= '0;
            seen     <= '0;
            update_r <= 1'b0;
            frame_r  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) age[i] <= '0;
        end else begin
            update_r <= capture;
            frame_r  <= capture && (&seen_nx);
            if (capture) seen <= (&seen_nx) ? '0 : seen_nx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                // A capture wins over a timeout landing in the same cycle.
                if (capture && cap_idx == idx_t'(i)) begin
                    digits_r[4*i +: 4] <= dec_nib;   // decoder already yields 0 on illegal
                    dp_r[i]            <= ~s_dp;
                    err_r[i]           <= dec_err;
                    valid_r[i]         <= 1'b1;
                    age[i]             <= '0;
                end else if (age[i] != AGE_MAX) begin
                    age[i] <= age[i] + AGE_W'(1);
                    if (age[i] == AGE_MAX - AGE_W'(1)) valid_r[i] <= 1'b0;
                end
            end
        end
    end

    assign ssd_scan_decoder_port_digits     = digits_r;
    assign ssd_scan_decoder_port_dp_out     = dp_r;
    assign ssd_scan_decoder_port_valid      = valid_r;
    assign ssd_scan_decoder_port_err        = err_r;
    assign ssd_scan_decoder_port_update     = update_r;
    assign ssd_scan_decoder_port_frame_done = frame_r;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: directed tables, corner sequences and random bus traffic
// checked cycle by cycle against a run-length reference model.
// Two instances share the bus: default timeout, and a short timeout of 50 cycles.
module tb_ssd_scan_decoder;

    localparam int STABLE = 4;
    localparam int TO_A   = 1_000_000;
    localparam int TO_B   = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  an  = 8'hFF;
    logic [6:0]  cc  = 7'h7F;
    logic        dp  = 1'b1;

    logic [31:0] dig_a, dig_b;
    logic [7:0]  dpo_a, dpo_b, val_a, val_b, err_a, err_b;
    logic        upd_a, upd_b, fd_a, fd_b;

    always #5 clk = ~clk;

    ssd_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TO_A)) dut (
        .ssd_scan_decoder_port_clk(clk), .ssd_scan_decoder_port_rst(rst),
        .ssd_scan_decoder_port_an(an), .ssd_scan_decoder_port_cc(cc), .ssd_scan_decoder_port_dp(dp),
        .ssd_scan_decoder_port_digits(dig_a), .ssd_scan_decoder_port_dp_out(dpo_a),
        .ssd_scan_decoder_port_valid(val_a), .ssd_scan_decoder_port_err(err_a),
        .ssd_scan_decoder_port_update(upd_a), .ssd_scan_decoder_port_frame_done(fd_a)
    );

    ssd_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TO_B)) dut_to (
        .ssd_scan_decoder_port_clk(clk), .ssd_scan_decoder_port_rst(rst),
        .ssd_scan_decoder_port_an(an), .ssd_scan_decoder_port_cc(cc), .ssd_scan_decoder_port_dp(dp),
        .ssd_scan_decoder_port_digits(dig_b), .ssd_scan_decoder_port_dp_out(dpo_b),
        .ssd_scan_decoder_port_valid(val_b), .ssd_scan_decoder_port_err(err_b),
        .ssd_scan_decoder_port_update(upd_b), .ssd_scan_decoder_port_frame_done(fd_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Legal active-low glyphs for 0..F
    logic [6:0] cc_tab [16];

    // ---------------- reference model ----------------
    // Synchronized sample = bus value two edges earlier. A capture happens when
    // a run of identical samples showing exactly one anode reaches STABLE long,
    // except the run that starts with the first real sample after reset.
    int          n_edge, edge_no, run;
    bit          stale;
    logic [15:0] m_raw1, m_raw2, m_last;
    logic [31:0] m_digits;
    logic [7:0]  m_dp, m_err, m_seen, m_cap;
    logic        m_upd, m_fd;
    int          cap_edge [8];

    task automatic model_reset();
        n_edge = 0; run = 0; stale = 1'b1;
        m_digits = '0; m_dp = '0; m_err = '0; m_seen = '0; m_cap = '0;
        m_upd = 1'b0; m_fd = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] s;
        int idx;
        logic [3:0] nib;
        logic ill;
        n_edge++;
        edge_no++;
        s = m_raw2;
        m_raw2 = m_raw1;
        m_raw1 = {an, cc, dp};
        m_upd = 1'b0;
        m_fd  = 1'b0;
        if (n_edge >= 3) begin
            if (n_edge == 3 || s != m_last) begin
                run = 1;
                stale = (n_edge == 3);
            end else begin
                run++;
            end
            m_last = s;
            if (!stale && run == STABLE && $countones(~s[15:8]) == 1) begin
                idx = 0;
                for (int i = 0; i < 8; i++) if (!s[8+i]) idx = i;
                nib = 4'h0;
                ill = 1'b1;
                for (int v = 0; v < 16; v++) begin
                    if (s[7:1] == cc_tab[v]) begin
                        nib = 4'(v);
                        ill = 1'b0;
                    end
                end
                m_digits[idx*4 +: 4] = nib;
                m_dp[idx]  = ~s[0];
                m_err[idx] = ill;
                m_cap[idx] = 1'b1;
                cap_edge[idx] = edge_no;
                m_upd = 1'b1;
                m_seen[idx] = 1'b1;
                if (&m_seen) begin
                    m_fd = 1'b1;
                    m_seen = '0;
                end
            end
        end
    endtask

    function automatic logic [7:0] model_valid(input int to);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_cap[i] && ((edge_no - cap_edge[i]) < to);
        return v;
    endfunction

    task automatic compare_model();
        check("model digits A", dig_a, m_digits);
        check("model dp_out A", 32'(dpo_a), 32'(m_dp));
        check("model valid A", 32'(val_a), 32'(model_valid(TO_A)));
        check("model err A", 32'(err_a), 32'(m_err));
        check("model update A", 32'(upd_a), 32'(m_upd));
        check("model frame_done A", 32'(fd_a), 32'(m_fd));
        check("model digits B", dig_b, m_digits);
        check("model dp_out B", 32'(dpo_b), 32'(m_dp));
        check("model valid B", 32'(val_b), 32'(model_valid(TO_B)));
        check("model err B", 32'(err_b), 32'(m_err));
        check("model update B", 32'(upd_b), 32'(m_upd));
        check("model frame_done B", 32'(fd_b), 32'(m_fd));
    endtask

    // One clock: model sees the same bus value the DUT samples; outputs checked 1ns later.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        compare_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic drive(input logic [7:0] a, input logic [6:0] c, input logic d);
        an = a; cc = c; dp = d;
    endtask

    typedef struct {
        logic [6:0] cc;
        logic       dp;
        logic [3:0] exp_nib;
        logic       exp_dp;
    } sweep_t;
    sweep_t sweep [16];

    initial begin
        int upd_cnt, fd_cnt, drop_k, cap_ok;

        cc_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                   7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        sweep[0]  = '{7'h01, 1'b0, 4'h0, 1'b1};
        sweep[1]  = '{7'h4F, 1'b1, 4'h1, 1'b0};
        sweep[2]  = '{7'h12, 1'b0, 4'h2, 1'b1};
        sweep[3]  = '{7'h06, 1'b1, 4'h3, 1'b0};
        sweep[4]  = '{7'h4C, 1'b0, 4'h4, 1'b1};
        sweep[5]  = '{7'h24, 1'b1, 4'h5, 1'b0};
        sweep[6]  = '{7'h20, 1'b0, 4'h6, 1'b1};
        sweep[7]  = '{7'h0F, 1'b1, 4'h7, 1'b0};
        sweep[8]  = '{7'h00, 1'b0, 4'h8, 1'b1};
        sweep[9]  = '{7'h04, 1'b1, 4'h9, 1'b0};
        sweep[10] = '{7'h08, 1'b0, 4'hA, 1'b1};
        sweep[11] = '{7'h60, 1'b1, 4'hB, 1'b0};
        sweep[12] = '{7'h31, 1'b0, 4'hC, 1'b1};
        sweep[13] = '{7'h42, 1'b1, 4'hD, 1'b0};
        sweep[14] = '{7'h30, 1'b0, 4'hE, 1'b1};
        sweep[15] = '{7'h38, 1'b1, 4'hF, 1'b0};

        edge_no = 0;
        for (int i = 0; i < 8; i++) cap_edge[i] = 0;
        m_raw1 = '1; m_raw2 = '1; m_last = '1;
        model_reset();

        // Reset state
        ticks(3);
        check("reset digits", dig_a, 32'h0);
        check("reset dp_out", 32'(dpo_a), 32'h0);
        check("reset valid", 32'(val_a), 32'h0);
        check("reset err", 32'(err_a), 32'h0);
        check("reset update", 32'(upd_a), 32'h0);
        check("reset frame_done", 32'(fd_a), 32'h0);
        rst = 1'b0;
        ticks(5);

        // Decode sweep on digit 0
        for (int k = 0; k < 16; k++) begin
            drive(8'hFE, sweep[k].cc, sweep[k].dp);
            upd_cnt = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (upd_a) upd_cnt++;
            end
            check($sformatf("sweep%0d updates", k), 32'(upd_cnt), 32'd1);
            check($sformatf("sweep%0d nibble", k), 32'(dig_a[3:0]), 32'(sweep[k].exp_nib));
            check($sformatf("sweep%0d dp_out", k), 32'(dpo_a[0]), 32'(sweep[k].exp_dp));
            check($sformatf("sweep%0d err", k), 32'(err_a[0]), 32'h0);
        end

        // Full frame: digits 0..7 show 1..8
        drive(8'hFF, 7'h7F, 1'b1);
        ticks(2);
        do_reset();
        ticks(5);
        fd_cnt = 0;
        for (int d = 0; d < 8; d++) begin
            drive(~(8'h01 << d), cc_tab[d+1], 1'b1);
            upd_cnt = 0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (upd_a) upd_cnt++;
                if (fd_a) begin
                    fd_cnt++;
                    check("frame_done with update", 32'(upd_a), 32'h1);
                    check("frame_done on digit 7", 32'(d), 32'd7);
                end
            end
            check($sformatf("frame digit%0d updates", d), 32'(upd_cnt), 32'd1);
        end
        check("frame digits", dig_a, 32'h87654321);
        check("frame valid", 32'(val_a), 32'hFF);
        check("frame_done count", 32'(fd_cnt), 32'd1);

        // Glitch: 3-sample anode/cathode burst from an idle bus
        drive(8'hFF, 7'h7F, 1'b1);
        ticks(10);
        drive(8'hFD, cc_tab[5], 1'b1);
        ticks(3);
        drive(8'hFF, 7'h7F, 1'b1);
        upd_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (upd_a) upd_cnt++;
        end
        check("glitch no update", 32'(upd_cnt), 32'd0);
        check("glitch digit1 kept", 32'(dig_a[7:4]), 32'h2);

        // Legal then illegal pattern on digit 1
        drive(8'hFD, cc_tab[9], 1'b1);
        ticks(10);
        check("digit1 nine", 32'(dig_a[7:4]), 32'h9);
        check("digit1 err clear", 32'(err_a[1]), 32'h0);
        drive(8'hFD, 7'h7F, 1'b1);
        upd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (upd_a) upd_cnt++;
        end
        check("illegal update", 32'(upd_cnt), 32'd1);
        check("illegal err", 32'(err_a[1]), 32'h1);
        check("illegal nibble", 32'(dig_a[7:4]), 32'h0);

        // Two anodes low: no capture
        drive(8'hFC, cc_tab[3], 1'b1);
        upd_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (upd_a) upd_cnt++;
        end
        check("two anodes no update", 32'(upd_cnt), 32'd0);

        // Timeout on the short-timeout instance
        drive(8'hFF, 7'h7F, 1'b1);
        ticks(2);
        do_reset();
        ticks(5);
        drive(8'hFB, cc_tab[6], 1'b0);
        cap_ok = 0;
        for (int c = 0; c < 20 && cap_ok == 0; c++) begin
            tick();
            if (upd_b) cap_ok = 1;
        end
        check("timeout capture seen", 32'(cap_ok), 32'd1);
        drive(8'hFF, 7'h7F, 1'b1);
        drop_k = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (drop_k < 0 && !val_b[2]) drop_k = k;
        end
        check("timeout drop cycle", 32'(drop_k), 32'd50);
        check("timeout digit kept", 32'(dig_b[11:8]), 32'h6);
        check("timeout dp kept", 32'(dpo_b[2]), 32'h1);
        check("long timeout still valid", 32'(val_a[2]), 32'h1);

        // Reset two cycles into SETTLE
        drive(8'hF7, cc_tab[12], 1'b0);
        ticks(8);
        check("pre-reset digit3", 32'(dig_a[15:12]), 32'hC);
        drive(8'hFE, cc_tab[10], 1'b1);
        ticks(4);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async rst digits", dig_a, 32'h0);
        check("async rst dp_out", 32'(dpo_a), 32'h0);
        check("async rst valid", 32'(val_a), 32'h0);
        check("async rst err", 32'(err_a), 32'h0);
        check("async rst update", 32'(upd_a), 32'h0);
        check("async rst frame_done", 32'(fd_a), 32'h0);
        ticks(2);
        rst = 1'b0;
        upd_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (upd_a || upd_b) upd_cnt++;
        end
        check("no capture after reset", 32'(upd_cnt), 32'd0);

        // Random bus traffic
        for (int seg = 0; seg < 320; seg++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) an = 8'hFF;
            else if (r == 1) an = 8'($urandom);
            else an = ~(8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 99) < 85) cc = cc_tab[$urandom_range(0, 15)];
            else cc = 7'($urandom);
            dp = 1'($urandom);
            ticks(int'($urandom_range(1, 12)));
            if ($urandom_range(0, 59) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
